// File: rtl/ee357_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ee357_ctrl_pkg
// Shared definitions for the multicycle control FSM of the 32-bit datapath:
//   - state encodings (plain localparams plus the state enum built on them)
//   - opcode constants for the supported instruction classes
//   - encodings of the alu_op, alu_src_b and pc_source select fields
//   - helper that identifies the states that wait on mem_ready
// ---------------------------------------------------------------------------
package ee357_ctrl_pkg;

   localparam int STATE_BITS = 4;

   // State encodings
   localparam logic [STATE_BITS-1:0] ST_IDLE   = 4'd0;
   localparam logic [STATE_BITS-1:0] ST_FETCH  = 4'd1;
   localparam logic [STATE_BITS-1:0] ST_DECODE = 4'd2;
   localparam logic [STATE_BITS-1:0] ST_MEMADR = 4'd3;
   localparam logic [STATE_BITS-1:0] ST_MEMRD  = 4'd4;
   localparam logic [STATE_BITS-1:0] ST_MEMWB  = 4'd5;
   localparam logic [STATE_BITS-1:0] ST_MEMWR  = 4'd6;
   localparam logic [STATE_BITS-1:0] ST_REXEC  = 4'd7;
   localparam logic [STATE_BITS-1:0] ST_RWB    = 4'd8;
   localparam logic [STATE_BITS-1:0] ST_BEQ    = 4'd9;
   localparam logic [STATE_BITS-1:0] ST_ADDIEX = 4'd10;
   localparam logic [STATE_BITS-1:0] ST_ADDIWB = 4'd11;
   localparam logic [STATE_BITS-1:0] ST_JUMP   = 4'd12;
   localparam logic [STATE_BITS-1:0] ST_HALT   = 4'd13;

   typedef enum logic [STATE_BITS-1:0] {
      IDLE   = ST_IDLE,
      FETCH  = ST_FETCH,
      DECODE = ST_DECODE,
      MEMADR = ST_MEMADR,
      MEMRD  = ST_MEMRD,
      MEMWB  = ST_MEMWB,
      MEMWR  = ST_MEMWR,
      REXEC  = ST_REXEC,
      RWB    = ST_RWB,
      BEQ    = ST_BEQ,
      ADDIEX = ST_ADDIEX,
      ADDIWB = ST_ADDIWB,
      JUMP   = ST_JUMP,
      HALT   = ST_HALT
   } state_e;

   // Opcode field IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation select
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B-operand mux select
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BROFF = 2'b11;

   // PC source mux select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold on the memory handshake and feed the wait counter
   function automatic logic is_mem_state(input state_e s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/ee357_mc_control.sv
// ---------------------------------------------------------------------------
// ee357_mc_control
// Multicycle control FSM. Sequences the datapath mux selects, register-file
// and memory enables and PC update for each instruction class. Memory states
// stall on mem_ready; an optional wait counter forces HALT (sticky mem_fault)
// when a memory access exceeds MEM_TIMEOUT cycles.
//
// Handshake: in FETCH/MEMRD/MEMWR the request (mem_read or mem_write) is held
// every cycle until a cycle in which mem_ready=1; that cycle completes the
// access and the FSM leaves the state on the following edge.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   opcode[5:0]      IR[31:26], sampled only in DECODE and MEMADR
//   mem_ready        memory completes the current access this cycle
//   pc_write         unconditional PC load
//   pc_write_cond    PC load if ALU zero
//   i_or_d           address mux: 0=PC, 1=ALUOut
//   mem_read/write   memory requests
//   mem_to_reg       write-data mux: 0=ALUOut, 1=MDR
//   ir_write         IR load enable
//   reg_dst          write-reg mux: 0=rt, 1=rd
//   reg_write        register file write enable
//   alu_src_a        0=PC, 1=A
//   alu_src_b[1:0]   00=B, 01=4, 10=sign-ext imm, 11=imm<<2
//   alu_op[1:0]      00=add, 01=sub, 10=funct-decoded
//   pc_source[1:0]   00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op       one-cycle pulse in DECODE for an unsupported opcode
//   mem_fault        sticky, memory timeout occurred
//   state_out        current state encoding
// ---------------------------------------------------------------------------
module ee357_mc_control
   import ee357_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int STATE_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic               illegal_op,
   output logic               mem_fault,
   output logic [STATE_W-1:0] state_out
);

   // The counter only has to reach MEM_TIMEOUT-1: the cycle that would make
   // it MEM_TIMEOUT is the one that times out.
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             fault_q, fault_d;
   logic             timeout_hit;

   // mem_ready on the limit cycle wins, so the timeout requires it low.
   assign timeout_hit = (MEM_TIMEOUT > 0) && !mem_ready && (wait_q == WAIT_LIMIT);

   // ------------------------------------------------------------------
   // State, wait counter and fault register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   // Wait counter: clears whenever the state changes, counts stalled
   // memory cycles otherwise.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (is_mem_state(state_q) && !mem_ready) begin
         wait_d = wait_q + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Next state and Moore outputs (ir_write/pc_write in FETCH follow
   // mem_ready so the IR and PC load only on the completing cycle).
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;

      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end

         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) begin
               state_d = DECODE;
            end else if (timeout_hit) begin
               state_d = HALT;
               fault_d = 1'b1;
            end
         end

         DECODE: begin
            alu_src_b = SRCB_BROFF;
            unique case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = REXEC;
               OP_BEQ:       state_d = BEQ;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default: begin
                  state_d    = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end

         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            // Only lw/sw reach this state; anything but sw is treated as a load.
            state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
         end

         MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) begin
               state_d = MEMWB;
            end else if (timeout_hit) begin
               state_d = HALT;
               fault_d = 1'b1;
            end
         end

         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
         end

         MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               state_d = FETCH;
            end else if (timeout_hit) begin
               state_d = HALT;
               fault_d = 1'b1;
            end
         end

         REXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = RWB;
         end

         RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = FETCH;
         end

         BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            state_d       = FETCH;
         end

         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ADDIWB;
         end

         ADDIWB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end

         JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            state_d   = FETCH;
         end

         HALT: begin
            // Terminal until reset.
            state_d = HALT;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_fault = fault_q;
   assign state_out = STATE_W'(state_q);

endmodule
